// File: rtl/tone_generator.sv
// Square-wave tone generator: turns a registered note/octave code into a 50%-duty
// buzzer output, switching pitch only at half-period boundaries.
module tone_generator #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int CNT_W    = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   note_in,
   input  logic [1:0]   octave_in,
   output logic         buzzer,
   output logic [7:0]   led_out,
   output logic [3:0]   note_active,
   output logic         playing
);

   localparam int HALF_DO = CLK_FREQ / (2 * 523);
   localparam int HALF_RE = CLK_FREQ / (2 * 587);
   localparam int HALF_MI = CLK_FREQ / (2 * 659);
   localparam int HALF_FA = CLK_FREQ / (2 * 698);
   localparam int HALF_SO = CLK_FREQ / (2 * 784);
   localparam int HALF_LA = CLK_FREQ / (2 * 880);
   localparam int HALF_SI = CLK_FREQ / (2 * 988);

   typedef enum logic {IDLE, TONE} state_t;

   state_t             state, state_next;
   logic [3:0]         note_q, octave_q_unused_guard;
   logic [1:0]         octave_q;
   logic [3:0]         act_note, act_note_next;
   logic [1:0]         act_oct, act_oct_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic               buzzer_next, playing_next;
   logic [7:0]         led_next;
   logic [3:0]         note_active_next;
   logic [CNT_W-1:0]   base_half, period;

   assign octave_q_unused_guard = 4'd0;

   // Out-of-range codes are folded here so everything downstream sees clean values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         note_q   <= 4'd0;
         octave_q <= 2'd0;
      end else begin
         note_q   <= note_in[3] ? 4'd0 : note_in;
         octave_q <= (octave_in == 2'd3) ? 2'd1 : octave_in;
      end
   end

   always_comb begin
      case (act_note)
         4'd1:    base_half = CNT_W'(HALF_DO);
         4'd2:    base_half = CNT_W'(HALF_RE);
         4'd3:    base_half = CNT_W'(HALF_MI);
         4'd4:    base_half = CNT_W'(HALF_FA);
         4'd5:    base_half = CNT_W'(HALF_SO);
         4'd6:    base_half = CNT_W'(HALF_LA);
         4'd7:    base_half = CNT_W'(HALF_SI);
         default: base_half = '0;
      endcase
      case (act_oct)
         2'd0:    period = base_half << 1;
         2'd2:    period = base_half >> 1;
         default: period = base_half;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         act_note    <= 4'd0;
         act_oct     <= 2'd0;
         buzzer      <= 1'b0;
         led_out     <= 8'h00;
         note_active <= 4'd0;
         playing     <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         act_note    <= act_note_next;
         act_oct     <= act_oct_next;
         buzzer      <= buzzer_next;
         led_out     <= led_next;
         note_active <= note_active_next;
         playing     <= playing_next;
      end
   end

   always_comb begin
      state_next       = state;
      cnt_next         = cnt;
      act_note_next    = act_note;
      act_oct_next     = act_oct;
      buzzer_next      = buzzer;
      led_next         = led_out;
      note_active_next = note_active;
      playing_next     = playing;
      case (state)
         IDLE: begin
            cnt_next    = '0;
            buzzer_next = 1'b0;
            if (note_q != 4'd0) begin
               state_next       = TONE;
               buzzer_next      = 1'b1;
               act_note_next    = note_q;
               act_oct_next     = octave_q;
               led_next         = 8'b1 << note_q;
               note_active_next = note_q;
               playing_next     = 1'b1;
            end
         end
         TONE: begin
            if (cnt == period - 1'b1) begin
               // Input is only re-sampled here, so pitch never changes mid half-period.
               cnt_next = '0;
               if (note_q == 4'd0) begin
                  state_next       = IDLE;
                  buzzer_next      = 1'b0;
                  led_next         = 8'h00;
                  note_active_next = 4'd0;
                  playing_next     = 1'b0;
               end else begin
                  buzzer_next = ~buzzer;
                  if (note_q != act_note || octave_q != act_oct) begin
                     act_note_next    = note_q;
                     act_oct_next     = octave_q;
                     led_next         = 8'b1 << note_q;
                     note_active_next = note_q;
                  end
               end
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
